// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core's memory port
// and the data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: one outstanding load/store, fixed wait-state latency,
// RV32I byte/half/word access with sign/zero extension and error reporting.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  data_mem_responder_if.slave bus
);
  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam int          ADDR_MSB   = IDX_W + 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [2:0]  CNT_INIT   = 3'(LATENCY - 1);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  size;
  } req_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  req_t           req_q, req_live, cur;
  logic           accept, commit;
  logic           misaligned, out_of_range, bad_size, err;
  logic [IDX_W-1:0] idx;
  logic [1:0]     lane;
  logic [31:0]    lane_data, load_data, store_data;
  logic [3:0]     store_mask;
  logic [31:0]    rsp_rdata_q;
  logic           rsp_err_q;
  logic [31:0]    mem [DEPTH_WORDS];

  assign req_live = '{addr: bus.req_addr, we: bus.req_we, wdata: bus.req_wdata, size: bus.req_size};
  assign accept   = (state_q == IDLE) && bus.req_valid;
  // With LATENCY==1 the accept edge is also the commit edge, so decode the live request.
  assign cur      = (state_q == IDLE) ? req_live : req_q;
  assign commit   = (state_d == RESP) && (state_q != RESP);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d   = CNT_INIT;
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    misaligned   = ((cur.size[1:0] == 2'b01) && cur.addr[0]) ||
                   ((cur.size == SZ_W) && (cur.addr[1:0] != 2'b00));
    out_of_range = cur.addr >= BYTE_LIMIT;
    bad_size     = (cur.size == 3'b011) || (cur.size[2:1] == 2'b11) || (cur.we && cur.size[2]);
    err          = misaligned || out_of_range || bad_size;

    idx       = cur.addr[ADDR_MSB:2];
    lane      = cur.addr[1:0];
    lane_data = mem[idx] >> {lane, 3'b000};

    load_data = '0;
    case (cur.size)
      SZ_B:    load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      SZ_H:    load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      SZ_W:    load_data = lane_data;
      SZ_BU:   load_data = {24'd0, lane_data[7:0]};
      SZ_HU:   load_data = {16'd0, lane_data[15:0]};
      default: load_data = '0;
    endcase

    store_mask = 4'b0000;
    store_data = '0;
    case (cur.size)
      SZ_B: begin
        store_mask = 4'b0001 << lane;
        store_data = {4{cur.wdata[7:0]}};
      end
      SZ_H: begin
        store_mask = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{cur.wdata[15:0]}};
      end
      SZ_W: begin
        store_mask = 4'b1111;
        store_data = cur.wdata;
      end
      default: begin
        store_mask = 4'b0000;
        store_data = '0;
      end
    endcase
  end

  // NOTE: the memory array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (commit && cur.we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (store_mask[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= req_live;
      if (commit) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || cur.we) ? 32'd0 : load_data;
      end else if ((state_q == RESP) && bus.rsp_ready) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 4) checked against a
// byte-addressed reference memory with directed and randomized transactions.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int N     = 3;
  localparam int BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]       req_valid, req_we, rsp_ready;
  logic [N-1:0][31:0] req_addr, req_wdata;
  logic [N-1:0][2:0]  req_size;
  logic [N-1:0]       req_ready, rsp_valid, rsp_err;
  logic [N-1:0][31:0] rsp_rdata;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    data_mem_responder_if bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_we    = req_we[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.req_size  = req_size[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
    );
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl   [N][BYTES];
  bit         known [N][BYTES];

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory, access width from funct3.
  function automatic void model(int d, logic [31:0] addr, bit we, logic [31:0] wdata,
                                logic [2:0] size, output bit err,
                                output logic [31:0] rdata, output bit ok);
    int n;
    bit sgn;
    longint v;
    int a;
    n = 0; sgn = 0;
    case (size)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: n = 0;
    endcase
    rdata = 0;
    ok    = 1;
    err   = (n == 0) || (we && size[2]) || (addr >= 32'(BYTES));
    if (!err) err = (addr % n) != 0;
    if (err) return;
    a = int'(addr);
    if (we) begin
      for (int i = 0; i < n; i++) begin
        mdl[d][a+i]   = wdata[8*i +: 8];
        known[d][a+i] = 1;
      end
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        v = v + (longint'(mdl[d][a+i]) << (8 * i));
        if (!known[d][a+i]) ok = 0;
      end
      if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      rdata = v[31:0];
    end
  endfunction

  // Present a request from a negedge; returns at the negedge after the accept edge.
  task automatic issue(int d, logic [31:0] addr, bit we, logic [31:0] wdata, logic [2:0] size);
    int n = 0;
    req_addr[d]  = addr;
    req_we[d]    = we;
    req_wdata[d] = wdata;
    req_size[d]  = size;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", req_ready[d], 1'b1);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  // Called one cycle after acceptance; waits for the response, holds, handshakes.
  task automatic finish(int d, bit e_err, logic [31:0] e_rd, bit ok, int hold, string tag,
                        output logic [31:0] rd);
    int lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_lat", tag), lat, lat_of(d));
    check($sformatf("%s_err", tag), rsp_err[d], e_err);
    if (ok) check($sformatf("%s_rdata", tag), rsp_rdata[d], e_rd);
    rd = rsp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold_valid", tag), rsp_valid[d], 1'b1);
      check($sformatf("%s_hold_ready", tag), req_ready[d], 1'b0);
      if (ok) check($sformatf("%s_hold_rdata", tag), rsp_rdata[d], e_rd);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check($sformatf("%s_post_valid", tag), rsp_valid[d], 1'b0);
    check($sformatf("%s_post_rdata", tag), rsp_rdata[d], 32'd0);
    check($sformatf("%s_post_err", tag), rsp_err[d], 1'b0);
  endtask

  task automatic txn(int d, logic [31:0] addr, bit we, logic [31:0] wdata, logic [2:0] size,
                     int hold, string tag, output logic [31:0] rd);
    bit e_err, ok;
    logic [31:0] e_rd;
    model(d, addr, we, wdata, size, e_err, e_rd, ok);
    issue(d, addr, we, wdata, size);
    finish(d, e_err, e_rd, ok, hold, tag, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit e_err_a, ok_a, e_err_b, ok_b;
    logic [31:0] e_rd_a, e_rd_b;

    for (int d = 0; d < N; d++) begin
      req_valid[d] = 0; req_we[d] = 0; rsp_ready[d] = 0;
      req_addr[d] = 0; req_wdata[d] = 0; req_size[d] = 0;
      for (int i = 0; i < BYTES; i++) begin
        mdl[d][i] = 0;
        known[d][i] = 0;
      end
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check("rst_rsp_valid", rsp_valid[d], 1'b0);
      check("rst_req_ready", req_ready[d], 1'b1);
      check("rst_rdata", rsp_rdata[d], 32'd0);
      check("rst_err", rsp_err[d], 1'b0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Reset while a store waits: it must be dropped.
    issue(0, 32'h10, 1'b1, 32'hDEADBEEF, 3'b010);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid[0], 1'b0);
    check("midrst_req_ready", req_ready[0], 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    txn(0, 32'h10, 1'b0, 0, 3'b010, 0, "midrst_load", rd);
    check("midrst_dropped", rd == 32'hDEADBEEF, 1'b0);

    // Byte loads with sign/zero extension.
    txn(0, 32'h100, 1'b1, 32'h8081_7F01, 3'b010, 0, "st_w", rd);
    txn(0, 32'h100, 1'b0, 0, 3'b000, 0, "ld_b0", rd);
    txn(0, 32'h103, 1'b0, 0, 3'b000, 1, "ld_b3", rd);
    txn(0, 32'h103, 1'b0, 0, 3'b100, 0, "ld_bu3", rd);

    // Partial half store.
    txn(0, 32'h100, 1'b1, 32'h1122_3344, 3'b010, 0, "st_w2", rd);
    txn(0, 32'h102, 1'b1, 32'h0000_ABCD, 3'b001, 0, "st_h", rd);
    txn(0, 32'h100, 1'b0, 0, 3'b010, 0, "ld_w_merge", rd);
    txn(0, 32'h102, 1'b0, 0, 3'b101, 0, "ld_hu", rd);
    txn(0, 32'h102, 1'b0, 0, 3'b001, 0, "ld_h", rd);

    // Error cases leave memory untouched.
    txn(0, 32'h0, 1'b1, 32'h5A5A_5A5A, 3'b010, 0, "st_w0", rd);
    txn(0, 32'h104, 1'b1, 32'h0BAD_F00D, 3'b010, 0, "st_w104", rd);
    txn(0, 32'h102, 1'b0, 0, 3'b010, 0, "err_ld_w_mis", rd);
    txn(0, 32'h101, 1'b0, 0, 3'b001, 0, "err_ld_h_mis", rd);
    txn(0, 32'h104, 1'b1, 32'hFFFF_FFFF, 3'b011, 0, "err_st_sz011", rd);
    txn(0, 32'h104, 1'b1, 32'h0000_00EE, 3'b100, 0, "err_st_bu", rd);
    txn(0, 32'(BYTES), 1'b1, 32'h1234_5678, 3'b010, 0, "err_st_range", rd);
    txn(0, 32'(BYTES), 1'b0, 0, 3'b010, 0, "err_ld_range", rd);
    txn(0, 32'h104, 1'b0, 0, 3'b010, 0, "chk_w104", rd);
    txn(0, 32'h0, 1'b0, 0, 3'b010, 0, "chk_w0", rd);
    txn(0, 32'h100, 1'b0, 0, 3'b010, 0, "chk_w100", rd);

    // Back-pressure with a pending request that must wait for IDLE.
    model(0, 32'h100, 1'b0, 0, 3'b010, e_err_a, e_rd_a, ok_a);
    issue(0, 32'h100, 1'b0, 0, 3'b010);
    repeat (lat_of(0) - 1) @(negedge clk);
    check("bp_valid", rsp_valid[0], 1'b1);
    req_addr[0] = 32'h101; req_we[0] = 1'b0; req_size[0] = 3'b000; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rdata", rsp_rdata[0], e_rd_a);
      check("bp_req_ready", req_ready[0], 1'b0);
      check("bp_rsp_valid", rsp_valid[0], 1'b1);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check("bp_done_valid", rsp_valid[0], 1'b0);
    check("bp_next_ready", req_ready[0], 1'b1);
    model(0, 32'h101, 1'b0, 0, 3'b000, e_err_b, e_rd_b, ok_b);
    @(negedge clk);
    req_valid[0] = 1'b0;
    finish(0, e_err_b, e_rd_b, ok_b, 0, "bp_next", rd);

    // Other latency builds.
    for (int d = 1; d < N; d++) begin
      txn(d, 32'h200, 1'b1, $urandom, 3'b010, 0, "lat_st", rd);
      txn(d, 32'h200, 1'b0, 0, 3'b010, 2, "lat_ld_w", rd);
      txn(d, 32'h202, 1'b0, 0, 3'b101, 0, "lat_ld_hu", rd);
      txn(d, 32'h201, 1'b0, 0, 3'b000, 1, "lat_ld_b", rd);
    end

    // Randomized traffic over a prefilled window.
    for (int w = 0; w < 16; w++) txn(0, 32'h100 + 32'(4 * w), 1'b1, $urandom, 3'b010, 0, "fill", rd);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? (32'(BYTES) + 32'($urandom_range(0, 255)))
                                      : (32'h100 + 32'($urandom_range(0, 63)));
      txn(0, a, 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
          $urandom_range(0, 2), "rand", rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
